// File: rtl/tl_pkg.sv
// Shared TileLink-UL opcode constants, responder state encoding and an alignment helper.
`default_nettype none

package tl_pkg;

  localparam logic [2:0] TL_GET      = 3'd4;
  localparam logic [2:0] TL_PUT_FULL = 3'd0;
  localparam logic [2:0] TL_PUT_PART = 3'd1;
  localparam logic [2:0] TL_ACK      = 3'd0;
  localparam logic [2:0] TL_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } tl_slv_state_t;

  // Low address bits must be zero up to the transfer size; sizes above 3 are rejected elsewhere.
  function automatic logic tl_misaligned(input logic [2:0] addr_lo, input logic [2:0] size);
    case (size)
      3'd1:    tl_misaligned = addr_lo[0];
      3'd2:    tl_misaligned = |addr_lo[1:0];
      3'd3:    tl_misaligned = |addr_lo[2:0];
      default: tl_misaligned = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/tl_sram_array.sv
// Single-port byte-masked SRAM: synchronous write, combinational read.
`default_nettype none

module tl_sram_array #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_mask,
  input  logic [63:0]   i_wdata,
  output logic [63:0]   o_rdata
);

  logic [63:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 8; b++) begin
        if (i_mask[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/tl_sram_slave.sv
// TileLink-UL responder serving an on-chip SRAM, one outstanding transaction, programmable latency.
`default_nettype none

module tl_sram_slave
  import tl_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_a_valid,
  input  logic [2:0]  i_a_opcode,
  input  logic [2:0]  i_a_size,
  input  logic [3:0]  i_a_source,
  input  logic [63:0] i_a_address,
  input  logic [7:0]  i_a_mask,
  input  logic [63:0] i_a_data,
  output logic        o_a_ready,
  output logic        o_d_valid,
  output logic [2:0]  o_d_opcode,
  output logic [2:0]  o_d_size,
  output logic [3:0]  o_d_source,
  output logic [63:0] o_d_data,
  output logic        o_d_error,
  input  logic        i_d_ready
);

  localparam int         AW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] C_LAT = 4'(LATENCY);

  tl_slv_state_t r_state;
  logic [3:0]    r_cnt;
  logic [2:0]    r_opcode, r_size;
  logic [3:0]    r_source;
  logic [63:0]   r_addr, r_data;
  logic [7:0]    r_mask;
  logic          r_a_ready, r_d_valid, r_d_error;
  logic [2:0]    r_d_opcode, r_d_size;
  logic [3:0]    r_d_source;
  logic [63:0]   r_d_data;

  // In IDLE the live channel-A request is decoded (needed for the zero-latency path),
  // otherwise the latched copy is.
  logic          w_live;
  logic [2:0]    w_opcode, w_size;
  logic [3:0]    w_source;
  logic [63:0]   w_addr, w_data, w_off, w_rdata;
  logic [7:0]    w_mask;
  logic          w_in_range, w_op_ok, w_err, w_is_put, w_is_get, w_enter_resp, w_we;
  logic [AW-1:0] w_word;

  assign w_live   = (r_state == S_IDLE);
  assign w_opcode = w_live ? i_a_opcode  : r_opcode;
  assign w_size   = w_live ? i_a_size    : r_size;
  assign w_source = w_live ? i_a_source  : r_source;
  assign w_addr   = w_live ? i_a_address : r_addr;
  assign w_mask   = w_live ? i_a_mask    : r_mask;
  assign w_data   = w_live ? i_a_data    : r_data;

  assign w_off      = w_addr - BASE_ADDR;
  assign w_word     = w_off[3 +: AW];
  assign w_in_range = (w_addr >= BASE_ADDR) && (w_off < (64'(DEPTH_WORDS) << 3));
  assign w_is_get   = (w_opcode == TL_GET);
  assign w_is_put   = (w_opcode == TL_PUT_FULL) || (w_opcode == TL_PUT_PART);
  assign w_op_ok    = w_is_get || w_is_put;
  assign w_err      = !w_in_range || (w_size > 3'd3) || tl_misaligned(w_addr[2:0], w_size) || !w_op_ok;

  assign w_enter_resp = ((r_state == S_IDLE) && i_a_valid && (LATENCY == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == C_LAT));
  assign w_we         = w_enter_resp && w_is_put && !w_err;

  tl_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_word),
    .i_mask  (w_mask),
    .i_wdata (w_data),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_opcode   <= 3'd0;
      r_size     <= 3'd0;
      r_source   <= 4'd0;
      r_addr     <= 64'd0;
      r_mask     <= 8'd0;
      r_data     <= 64'd0;
      r_a_ready  <= 1'b1;
      r_d_valid  <= 1'b0;
      r_d_opcode <= 3'd0;
      r_d_size   <= 3'd0;
      r_d_source <= 4'd0;
      r_d_data   <= 64'd0;
      r_d_error  <= 1'b0;
    end else begin
      if (w_enter_resp) begin
        r_state    <= S_RESP;
        r_a_ready  <= 1'b0;
        r_d_valid  <= 1'b1;
        r_d_opcode <= w_is_get ? TL_ACK_DATA : TL_ACK;
        r_d_size   <= w_size;
        r_d_source <= w_source;
        r_d_error  <= w_err;
        r_d_data   <= (w_is_get && !w_err) ? w_rdata : 64'd0;
      end
      case (r_state)
        S_IDLE: begin
          if (i_a_valid) begin
            r_opcode  <= i_a_opcode;
            r_size    <= i_a_size;
            r_source  <= i_a_source;
            r_addr    <= i_a_address;
            r_mask    <= i_a_mask;
            r_data    <= i_a_data;
            r_a_ready <= 1'b0;
            r_cnt     <= 4'd0;
            if (LATENCY != 0) r_state <= S_WAIT;
          end
        end
        // One decode cycle after the accept, then LATENCY counted cycles.
        S_WAIT: begin
          if (r_cnt != C_LAT) r_cnt <= r_cnt + 4'd1;
        end
        S_RESP: begin
          if (i_d_ready) begin
            r_state   <= S_IDLE;
            r_d_valid <= 1'b0;
            r_a_ready <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_a_ready <= 1'b1;
          r_d_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_a_ready  = r_a_ready;
  assign o_d_valid  = r_d_valid;
  assign o_d_opcode = r_d_opcode;
  assign o_d_size   = r_d_size;
  assign o_d_source = r_d_source;
  assign o_d_data   = r_d_data;
  assign o_d_error  = r_d_error;

endmodule

`default_nettype wire
